// File: rtl/pipe_datapath_pkg.sv
// Shared definitions for the pipelined datapath: opcode encodings, flag
// bit positions and the address-width rule.
package pipe_datapath_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_PASS = 4'd8;
    localparam logic [3:0] OP_ADC  = 4'd9;
    localparam logic [3:0] OP_SBC  = 4'd10;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_W     = 2;

    function automatic int addr_width(input int regCount);
        return (regCount < 2) ? 1 : $clog2(regCount);
    endfunction

endpackage

// File: rtl/alu_p.sv
// Combinational ALU; arithmetic ops use a one-bit-wider result so the top
// bit is the carry (ADD/ADC) or borrow (SUB/SBC).
module alu_p
    import pipe_datapath_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              carry_in,
    input  logic [3:0]        opcode,
    output logic [DATA_W-1:0] out,
    output logic              zero,
    output logic              carry
);

    logic [DATA_W:0] w_wide;
    logic [DATA_W:0] w_cin;

    assign w_cin = {{DATA_W{1'b0}}, carry_in};

    always_comb begin
        w_wide = '0;
        out    = '0;
        carry  = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_wide = {1'b0, a} + {1'b0, b};
                out    = w_wide[DATA_W-1:0];
                carry  = w_wide[DATA_W];
            end
            OP_SUB: begin
                w_wide = {1'b0, a} - {1'b0, b};
                out    = w_wide[DATA_W-1:0];
                carry  = w_wide[DATA_W];
            end
            OP_AND:  out = a & b;
            OP_OR:   out = a | b;
            OP_XOR:  out = a ^ b;
            OP_NOT:  out = ~a;
            OP_SHL: begin
                out   = {a[DATA_W-2:0], 1'b0};
                carry = a[DATA_W-1];
            end
            OP_SHR: begin
                out   = {1'b0, a[DATA_W-1:1]};
                carry = a[0];
            end
            OP_PASS: out = b;
            OP_ADC: begin
                w_wide = {1'b0, a} + {1'b0, b} + w_cin;
                out    = w_wide[DATA_W-1:0];
                carry  = w_wide[DATA_W];
            end
            OP_SBC: begin
                w_wide = {1'b0, a} - {1'b0, b} - w_cin;
                out    = w_wide[DATA_W-1:0];
                carry  = w_wide[DATA_W];
            end
            default: begin
                out   = '0;
                carry = 1'b0;
            end
        endcase
    end

    assign zero = (out == '0);

endmodule

// File: rtl/pipe_datapath.sv
// Two-stage datapath: EX reads forwarded operands and computes, WB registers
// the result and commits it to the register file one cycle later.
module pipe_datapath
    import pipe_datapath_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int REG_COUNT = 16,
    parameter int ADDR_W    = addr_width(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              alu_en,
    input  logic [3:0]        opcode,
    input  logic [DATA_W-1:0] user_data,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    input  logic [ADDR_W-1:0] wa_addr,
    input  logic              write_en,
    output logic [DATA_W-1:0] read_a,
    output logic [DATA_W-1:0] read_b,
    output logic              res_valid,
    output logic [ADDR_W-1:0] res_addr,
    output logic [DATA_W-1:0] res_data,
    output logic              zero_flag,
    output logic              carry_flag,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] r_regs [REG_COUNT];
    logic              r_wbValid;
    logic              r_wbWe;
    logic [ADDR_W-1:0] r_wbAddr;
    logic [DATA_W-1:0] r_wbData;
    logic [FLAG_W-1:0] r_flags;

    logic [DATA_W-1:0] w_aluOut;
    logic              w_aluZero;
    logic              w_aluCarry;
    logic [DATA_W-1:0] w_selData;
    logic              w_wbCommit;

    assign w_wbCommit = r_wbValid && r_wbWe;

    // The WB stage wins over the file so back-to-back dependencies need no bubble.
    always_comb begin
        read_a = '0;
        read_b = '0;
        if (ra_addr != '0) begin
            read_a = (w_wbCommit && (r_wbAddr == ra_addr)) ? r_wbData : r_regs[ra_addr];
        end
        if (rb_addr != '0) begin
            read_b = (w_wbCommit && (r_wbAddr == rb_addr)) ? r_wbData : r_regs[rb_addr];
        end
    end

    alu_p #(.DATA_W(DATA_W)) u_alu (
        .a        (read_a),
        .b        (read_b),
        .carry_in (r_flags[FLAG_CARRY]),
        .opcode   (opcode),
        .out      (w_aluOut),
        .zero     (w_aluZero),
        .carry    (w_aluCarry)
    );

    assign w_selData = alu_en ? w_aluOut : user_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wbValid <= 1'b0;
            r_wbWe    <= 1'b0;
            r_wbAddr  <= '0;
            r_wbData  <= '0;
            r_flags   <= '0;
        end else begin
            r_wbValid <= in_valid;
            if (in_valid) begin
                r_wbWe   <= write_en;
                r_wbAddr <= wa_addr;
                r_wbData <= w_selData;
            end
            if (in_valid && alu_en) begin
                r_flags[FLAG_ZERO]  <= w_aluZero;
                r_flags[FLAG_CARRY] <= w_aluCarry;
            end
        end
    end

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wbCommit && (r_wbAddr != '0)) begin
            r_regs[r_wbAddr] <= r_wbData;
        end
    end

    assign res_valid  = r_wbValid;
    assign res_addr   = r_wbAddr;
    assign res_data   = r_wbData;
    assign zero_flag  = r_flags[FLAG_ZERO];
    assign carry_flag = r_flags[FLAG_CARRY];
    assign dbg_data   = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

endmodule

// File: tb/tb_pipe_datapath.sv
// Self-checking bench: a cycle-level behavioural model of the 8-bit/16-register
// datapath checked every cycle, directed scenarios with literal expectations,
// and a second 16-bit/32-register instance for the parameter sweep.
module tb_pipe_datapath;
    import pipe_datapath_pkg::*;

    localparam int DW  = 8;
    localparam int RC  = 16;
    localparam int AW  = 4;
    localparam int WDW = 16;
    localparam int WRC = 32;
    localparam int WAW = 5;

    logic          clk;
    logic          rst_n;
    logic          inValid;
    logic          aluEn;
    logic [3:0]    opcode;
    logic [DW-1:0] userData;
    logic [AW-1:0] raAddr;
    logic [AW-1:0] rbAddr;
    logic [AW-1:0] waAddr;
    logic          writeEn;
    logic [DW-1:0] readA;
    logic [DW-1:0] readB;
    logic          resValid;
    logic [AW-1:0] resAddr;
    logic [DW-1:0] resData;
    logic          zeroFlag;
    logic          carryFlag;
    logic [AW-1:0] dbgAddr;
    logic [DW-1:0] dbgData;

    logic           wideRstN;
    logic           wideInValid;
    logic           wideAluEn;
    logic [3:0]     wideOpcode;
    logic [WDW-1:0] wideUserData;
    logic [WAW-1:0] wideRaAddr;
    logic [WAW-1:0] wideRbAddr;
    logic [WAW-1:0] wideWaAddr;
    logic           wideWriteEn;
    logic [WDW-1:0] wideReadA;
    logic [WDW-1:0] wideReadB;
    logic           wideResValid;
    logic [WAW-1:0] wideResAddr;
    logic [WDW-1:0] wideResData;
    logic           wideZeroFlag;
    logic           wideCarryFlag;
    logic [WAW-1:0] wideDbgAddr;
    logic [WDW-1:0] wideDbgData;

    pipe_datapath #(.DATA_W(DW), .REG_COUNT(RC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (inValid),
        .alu_en     (aluEn),
        .opcode     (opcode),
        .user_data  (userData),
        .ra_addr    (raAddr),
        .rb_addr    (rbAddr),
        .wa_addr    (waAddr),
        .write_en   (writeEn),
        .read_a     (readA),
        .read_b     (readB),
        .res_valid  (resValid),
        .res_addr   (resAddr),
        .res_data   (resData),
        .zero_flag  (zeroFlag),
        .carry_flag (carryFlag),
        .dbg_addr   (dbgAddr),
        .dbg_data   (dbgData)
    );

    pipe_datapath #(.DATA_W(WDW), .REG_COUNT(WRC)) dutWide (
        .clk        (clk),
        .rst_n      (wideRstN),
        .in_valid   (wideInValid),
        .alu_en     (wideAluEn),
        .opcode     (wideOpcode),
        .user_data  (wideUserData),
        .ra_addr    (wideRaAddr),
        .rb_addr    (wideRbAddr),
        .wa_addr    (wideWaAddr),
        .write_en   (wideWriteEn),
        .read_a     (wideReadA),
        .read_b     (wideReadB),
        .res_valid  (wideResValid),
        .res_addr   (wideResAddr),
        .res_data   (wideResData),
        .zero_flag  (wideZeroFlag),
        .carry_flag (wideCarryFlag),
        .dbg_addr   (wideDbgAddr),
        .dbg_data   (wideDbgData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model state: architectural registers, the retiring op and the flags.
    int mRegs [RC];
    bit mWbValid;
    bit mWbWe;
    int mWbAddr;
    int mWbData;
    bit mZero;
    bit mCarry;

    int nRegs [RC];
    bit nWbValid;
    bit nWbWe;
    int nWbAddr;
    int nWbData;
    bit nZero;
    bit nCarry;

    function automatic int modelRead(input int addr);
        if (addr == 0) return 0;
        if (mWbValid && mWbWe && mWbAddr == addr) return mWbData;
        return mRegs[addr];
    endfunction

    // Plain integer arithmetic over 0..255, independent of any bit-slicing.
    function automatic void modelAlu(input int op, input int a, input int b, input int cin,
                                     output int res, output bit cy);
        int s;
        res = 0;
        cy  = 1'b0;
        case (op)
            0: begin s = a + b; res = s % 256; cy = (s >= 256); end
            1: begin res = (a - b + 256) % 256; cy = (a < b); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = 255 - a;
            6: begin res = (a * 2) % 256; cy = (a >= 128); end
            7: begin res = a / 2; cy = (a % 2 == 1); end
            8: res = b;
            9: begin s = a + b + cin; res = s % 256; cy = (s >= 256); end
            10: begin res = (a - b - cin + 512) % 256; cy = (a < b + cin); end
            default: begin res = 0; cy = 1'b0; end
        endcase
    endfunction

    // Compare process: check every output on the falling edge, then predict the next state.
    always @(negedge clk) begin
        int a;
        int b;
        int res;
        bit cy;
        if (!rst_n) begin
            for (int i = 0; i < RC; i++) mRegs[i] = 0;
            mWbValid = 1'b0;
            mWbWe    = 1'b0;
            mWbAddr  = 0;
            mWbData  = 0;
            mZero    = 1'b0;
            mCarry   = 1'b0;
        end
        a = modelRead(int'(raAddr));
        b = modelRead(int'(rbAddr));
        checkOutput("model read_a", int'(readA), a);
        checkOutput("model read_b", int'(readB), b);
        checkOutput("model res_valid", int'(resValid), int'(mWbValid));
        if (mWbValid) begin
            checkOutput("model res_addr", int'(resAddr), mWbAddr);
            checkOutput("model res_data", int'(resData), mWbData);
        end
        checkOutput("model zero_flag", int'(zeroFlag), int'(mZero));
        checkOutput("model carry_flag", int'(carryFlag), int'(mCarry));
        checkOutput("model dbg_data", int'(dbgData), mRegs[int'(dbgAddr)]);

        nRegs    = mRegs;
        nWbValid = mWbValid;
        nWbWe    = mWbWe;
        nWbAddr  = mWbAddr;
        nWbData  = mWbData;
        nZero    = mZero;
        nCarry   = mCarry;
        if (rst_n) begin
            if (mWbValid && mWbWe && mWbAddr != 0) nRegs[mWbAddr] = mWbData;
            modelAlu(int'(opcode), a, b, int'(mCarry), res, cy);
            nWbValid = inValid;
            if (inValid) begin
                nWbWe   = writeEn;
                nWbAddr = int'(waAddr);
                nWbData = aluEn ? res : int'(userData);
                if (aluEn) begin
                    nZero  = (res == 0);
                    nCarry = cy;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            mRegs    = nRegs;
            mWbValid = nWbValid;
            mWbWe    = nWbWe;
            mWbAddr  = nWbAddr;
            mWbData  = nWbData;
            mZero    = nZero;
            mCarry   = nCarry;
        end
    end

    task automatic applyStimulus(input bit v, input bit ae, input int op, input int ud,
                                 input int ra, input int rb, input int wa, input bit we);
        @(posedge clk);
        #1;
        inValid  = v;
        aluEn    = ae;
        opcode   = op[3:0];
        userData = ud[DW-1:0];
        raAddr   = ra[AW-1:0];
        rbAddr   = rb[AW-1:0];
        waAddr   = wa[AW-1:0];
        writeEn  = we;
    endtask

    task automatic applyWide(input bit v, input bit ae, input int op, input int ud,
                             input int ra, input int rb, input int wa, input bit we);
        @(posedge clk);
        #1;
        wideInValid  = v;
        wideAluEn    = ae;
        wideOpcode   = op[3:0];
        wideUserData = ud[WDW-1:0];
        wideRaAddr   = ra[WAW-1:0];
        wideRbAddr   = rb[WAW-1:0];
        wideWaAddr   = wa[WAW-1:0];
        wideWriteEn  = we;
    endtask

    initial begin
        rst_n        = 1'b0;
        inValid      = 1'b0;
        aluEn        = 1'b0;
        opcode       = '0;
        userData     = '0;
        raAddr       = '0;
        rbAddr       = '0;
        waAddr       = '0;
        writeEn      = 1'b0;
        dbgAddr      = '0;
        wideRstN     = 1'b0;
        wideInValid  = 1'b0;
        wideAluEn    = 1'b0;
        wideOpcode   = '0;
        wideUserData = '0;
        wideRaAddr   = '0;
        wideRbAddr   = '0;
        wideWaAddr   = '0;
        wideWriteEn  = 1'b0;
        wideDbgAddr  = '0;

        repeat (3) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        wideRstN = 1'b1;
        dbgAddr  = 4'd3;
        @(negedge clk);
        checkOutput("reset res_valid", int'(resValid), 0);
        checkOutput("reset zero_flag", int'(zeroFlag), 0);
        checkOutput("reset carry_flag", int'(carryFlag), 0);
        checkOutput("reset wide res_valid", int'(wideResValid), 0);

        // Back-to-back forwarding into an ADD.
        applyStimulus(1, 0, 0, 'h12, 0, 0, 1, 1);
        applyStimulus(1, 0, 0, 'h34, 0, 0, 2, 1);
        applyStimulus(1, 1, OP_ADD, 0, 1, 2, 3, 1);
        @(negedge clk);
        checkOutput("fwd read_a", int'(readA), 'h12);
        checkOutput("fwd read_b", int'(readB), 'h34);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("fwd res_valid", int'(resValid), 1);
        checkOutput("fwd res_addr", int'(resAddr), 3);
        checkOutput("fwd res_data", int'(resData), 'h46);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("fwd dbg r3", int'(dbgData), 'h46);

        // Carry chain: ADD FF+01 then ADC 0+0 picks up the carry.
        applyStimulus(1, 0, 0, 'hFF, 0, 0, 4, 1);
        applyStimulus(1, 0, 0, 'h01, 0, 0, 5, 1);
        applyStimulus(1, 1, OP_ADD, 0, 4, 5, 6, 1);
        applyStimulus(1, 1, OP_ADC, 0, 0, 0, 7, 1);
        @(negedge clk);
        checkOutput("carry add res_data", int'(resData), 'h00);
        checkOutput("carry add zero", int'(zeroFlag), 1);
        checkOutput("carry add carry", int'(carryFlag), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("carry adc res_data", int'(resData), 'h01);
        checkOutput("carry adc carry", int'(carryFlag), 0);
        checkOutput("carry adc zero", int'(zeroFlag), 0);

        // Register 0 discards writes and always reads as zero.
        applyStimulus(1, 0, 0, 'h77, 0, 0, 0, 1);
        applyStimulus(1, 1, OP_OR, 0, 0, 0, 9, 0);
        dbgAddr = 4'd0;
        @(negedge clk);
        checkOutput("r0 read_a", int'(readA), 0);
        checkOutput("r0 read_b", int'(readB), 0);
        checkOutput("r0 dbg", int'(dbgData), 0);

        // Flags hold across a user-data write.
        applyStimulus(1, 0, 0, 'h03, 0, 0, 8, 1);
        applyStimulus(1, 0, 0, 'h05, 0, 0, 9, 1);
        applyStimulus(1, 1, OP_SUB, 0, 8, 9, 10, 1);
        applyStimulus(1, 0, 0, 'h99, 0, 0, 11, 1);
        @(negedge clk);
        checkOutput("sub res_data", int'(resData), 'hFE);
        checkOutput("sub carry", int'(carryFlag), 1);
        checkOutput("sub zero", int'(zeroFlag), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("hold res_data", int'(resData), 'h99);
        checkOutput("hold carry", int'(carryFlag), 1);
        checkOutput("hold zero", int'(zeroFlag), 0);

        // Reset while a write of 0x5A to r3 is sitting in WB.
        applyStimulus(1, 0, 0, 'h5A, 0, 0, 3, 1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        rst_n   = 1'b0;
        dbgAddr = 4'd3;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst dbg r3", int'(dbgData), 0);
        checkOutput("rst zero", int'(zeroFlag), 0);
        checkOutput("rst carry", int'(carryFlag), 0);
        checkOutput("rst res_valid", int'(resValid), 0);

        // Randomized traffic checked by the model.
        repeat (600) begin
            applyStimulus(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, RC - 1)), int'($urandom_range(0, RC - 1)),
                          int'($urandom_range(0, RC - 1)), ($urandom_range(0, 4) != 0));
            dbgAddr = AW'($urandom_range(0, RC - 1));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        // Wide instance: SHL 0x8001 and the top register r31.
        applyWide(1, 0, 0, 'h8001, 0, 0, 31, 1);
        applyWide(1, 1, OP_SHL, 0, 31, 0, 30, 1);
        @(negedge clk);
        checkOutput("wide read_a r31", int'(wideReadA), 'h8001);
        applyWide(0, 0, 0, 0, 0, 0, 0, 0);
        wideDbgAddr = 5'd31;
        @(negedge clk);
        checkOutput("wide shl res_data", int'(wideResData), 'h0002);
        checkOutput("wide shl carry", int'(wideCarryFlag), 1);
        checkOutput("wide shl zero", int'(wideZeroFlag), 0);
        checkOutput("wide dbg r31", int'(wideDbgData), 'h8001);
        applyWide(0, 0, 0, 0, 0, 0, 0, 0);
        wideDbgAddr = 5'd30;
        @(negedge clk);
        checkOutput("wide dbg r30", int'(wideDbgData), 'h0002);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
